// File: rtl/mvma_rr_arbiter.sv
// mvma_rr_arbiter: two-requester round-robin front end for one shared vector layer.
// A granted requester streams N words into the layer (FEED), then the layer's M result
// words are streamed back to that same requester (DRAIN). Nothing is buffered; all
// stream paths are combinational pass-throughs selected by the current owner.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   s0_*/s1_*                     requester input streams (valid/ready/data)
//   l_s_valid/l_s_ready/l_data_in stream into the shared layer
//   l_m_valid/l_m_ready/l_data_out stream out of the shared layer
//   o0_*/o1_*                     result streams back to each requester
//   busy                          high whenever a transaction is in progress
//   grant                         index of the current owner
module mvma_rr_arbiter #(
   parameter int unsigned T = 12,
   parameter int unsigned N = 8,
   parameter int unsigned M = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         s0_valid,
   output logic         s0_ready,
   input  logic [T-1:0] s0_data,
   input  logic         s1_valid,
   output logic         s1_ready,
   input  logic [T-1:0] s1_data,
   output logic         l_s_valid,
   input  logic         l_s_ready,
   output logic [T-1:0] l_data_in,
   input  logic         l_m_valid,
   output logic         l_m_ready,
   input  logic [T-1:0] l_data_out,
   output logic         o0_valid,
   input  logic         o0_ready,
   output logic [T-1:0] o0_data,
   output logic         o1_valid,
   input  logic         o1_ready,
   output logic [T-1:0] o1_data,
   output logic         busy,
   output logic         grant
);

   typedef enum logic [1:0] {StIdle, StFeed, StDrain} state_e;

   localparam logic [3:0] InLast  = 4'(N - 1);
   localparam logic [3:0] OutLast = 4'(M - 1);

   state_e     state_q, state_d;
   logic       gnt_q, gnt_d;
   logic       last_q, last_d;
   logic [3:0] in_cnt_q, in_cnt_d;
   logic [3:0] out_cnt_q, out_cnt_d;

   logic         sel_valid;
   logic [T-1:0] sel_data;
   logic         sel_oready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         gnt_q     <= 1'b0;
         last_q    <= 1'b1;  // requester 0 wins the first tie
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;

      s0_ready  = 1'b0;
      s1_ready  = 1'b0;
      l_s_valid = 1'b0;
      l_data_in = '0;
      l_m_ready = 1'b0;
      o0_valid  = 1'b0;
      o0_data   = '0;
      o1_valid  = 1'b0;
      o1_data   = '0;

      sel_valid  = gnt_q ? s1_valid : s0_valid;
      sel_data   = gnt_q ? s1_data : s0_data;
      sel_oready = gnt_q ? o1_ready : o0_ready;

      unique case (state_q)
         StIdle: begin
            // Arbitration cycle only: no stream moves here.
            if (s0_valid && s1_valid) begin
               gnt_d   = ~last_q;
               state_d = StFeed;
            end else if (s0_valid) begin
               gnt_d   = 1'b0;
               state_d = StFeed;
            end else if (s1_valid) begin
               gnt_d   = 1'b1;
               state_d = StFeed;
            end
         end
         StFeed: begin
            l_s_valid = sel_valid;
            l_data_in = sel_valid ? sel_data : '0;
            if (gnt_q) s1_ready = l_s_ready;
            else       s0_ready = l_s_ready;
            if (sel_valid && l_s_ready) begin
               if (in_cnt_q == InLast) begin
                  in_cnt_d = '0;
                  state_d  = StDrain;
               end else begin
                  in_cnt_d = in_cnt_q + 4'd1;
               end
            end
         end
         StDrain: begin
            l_m_ready = sel_oready;
            if (gnt_q) begin
               o1_valid = l_m_valid;
               o1_data  = l_m_valid ? l_data_out : '0;
            end else begin
               o0_valid = l_m_valid;
               o0_data  = l_m_valid ? l_data_out : '0;
            end
            if (l_m_valid && sel_oready) begin
               if (out_cnt_q == OutLast) begin
                  out_cnt_d = '0;
                  last_d    = gnt_q;
                  state_d   = StIdle;
               end else begin
                  out_cnt_d = out_cnt_q + 4'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      busy  = (state_q != StIdle);
      grant = gnt_q;

      // Hold every handshake low while reset is asserted, regardless of stale state.
      if (reset) begin
         s0_ready  = 1'b0;
         s1_ready  = 1'b0;
         l_s_valid = 1'b0;
         l_data_in = '0;
         l_m_ready = 1'b0;
         o0_valid  = 1'b0;
         o0_data   = '0;
         o1_valid  = 1'b0;
         o1_data   = '0;
         busy      = 1'b0;
      end
   end

endmodule
